// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM lane demultiplexer.
package tdm_pkg;
  localparam int TDM_WIDTH      = 8;
  localparam int TDM_NUM_LANES  = 2;
  localparam int TDM_FIFO_DEPTH = 4;

  typedef enum logic {UNLOCKED, LOCKED} demux_state_t;
  typedef logic [$clog2(TDM_NUM_LANES)-1:0] slot_t;
endpackage

// File: rtl/tdm_lane_fifo.sv
// First-word-fall-through sync FIFO for one lane; head word is driven directly from storage.
module tdm_lane_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tdm_lane_demux.sv
// TDM receive demux: frame lock on SOF, slot counter, per-lane FWFT FIFOs, sticky flags.
// Define TDM_SOF_RESYNC_EN to realign on a mid-frame SOF and report it on sync_err.
module tdm_lane_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH      = TDM_WIDTH,
  parameter int NUM_LANES  = TDM_NUM_LANES,
  parameter int FIFO_DEPTH = TDM_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       din_sof,
  output logic [NUM_LANES*WIDTH-1:0] lane_dout,
  output logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES-1:0]       lane_ready,
  output logic                       aligned,
  output logic [NUM_LANES-1:0]       overflow,
  output logic                       sync_err
);
  localparam int SLOT_W = $clog2(NUM_LANES);

  demux_state_t                     state, state_n;
  logic [SLOT_W-1:0]                slot, slot_n;
  logic [NUM_LANES-1:0]             push, pop, full, empty;
  logic [NUM_LANES-1:0][WIDTH-1:0]  lane_word;
`ifdef TDM_SOF_RESYNC_EN
  logic                             resync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNLOCKED;
      slot  <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot;
    push    = '0;
`ifdef TDM_SOF_RESYNC_EN
    resync  = 1'b0;
`endif
    if (state == UNLOCKED) begin
      if (din_valid && din_sof) begin
        push[0] = 1'b1;
        slot_n  = SLOT_W'(1);
        state_n = LOCKED;
      end
    end else if (din_valid) begin
`ifdef TDM_SOF_RESYNC_EN
      if (din_sof && slot != '0) begin
        push[0] = 1'b1;
        slot_n  = SLOT_W'(1);
        resync  = 1'b1;
      end else
`endif
      begin
        push[slot] = 1'b1;
        slot_n     = (slot == SLOT_W'(NUM_LANES-1)) ? '0 : slot + SLOT_W'(1);
      end
    end
  end

  assign aligned    = (state == LOCKED);
  assign lane_valid = ~empty;
  assign pop        = lane_valid & lane_ready;
  assign lane_dout  = lane_word;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tdm_lane_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[k]),
      .pop  (pop[k]),
      .din  (din),
      .dout (lane_word[k]),
      .full (full[k]),
      .empty(empty[k])
    );
  end

  // A word is lost only when its FIFO is full and nothing leaves that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= '0;
    else      overflow <= overflow | (push & full & ~pop);
  end

`ifdef TDM_SOF_RESYNC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sync_err <= 1'b0;
    else if (resync) sync_err <= 1'b1;
  end
`else
  assign sync_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_lane_demux.sv
// Self-checking bench for tdm_lane_demux against a queue-based frame/lane model.
module tb_tdm_lane_demux;
  localparam int W  = 8;
  localparam int NL = 2;
  localparam int D  = 4;
  localparam bit RESYNC =
`ifdef TDM_SOF_RESYNC_EN
    1'b1;
`else
    1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [W-1:0]    din = '0;
  logic            din_valid = 1'b0;
  logic            din_sof = 1'b0;
  logic [NL*W-1:0] lane_dout;
  logic [NL-1:0]   lane_valid;
  logic [NL-1:0]   lane_ready = '0;
  logic            aligned;
  logic [NL-1:0]   overflow;
  logic            sync_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] q [NL][$];
  bit           m_locked;
  int           m_slot;
  bit [NL-1:0]  m_ovf;
  bit           m_serr;

  tdm_lane_demux #(.WIDTH(W), .NUM_LANES(NL), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .lane_dout(lane_dout), .lane_valid(lane_valid), .lane_ready(lane_ready),
    .aligned(aligned), .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_word(int k);
    return (q[k].size() != 0) ? q[k][0] : '0;
  endfunction

  function automatic logic exp_valid(int k);
    return q[k].size() != 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NL; k++) q[k].delete();
    m_locked = 0; m_slot = 0; m_ovf = '0; m_serr = 0;
  endtask

  // Drive one cycle, advance the model across the edge, return #1 after it.
  task automatic step(input logic [W-1:0] d, input logic v, input logic s, input logic [NL-1:0] r);
    bit [NL-1:0] pops;
    int tgt;
    din = d; din_valid = v; din_sof = s; lane_ready = r;
    @(posedge clk);
    tgt = -1;
    for (int k = 0; k < NL; k++) pops[k] = (q[k].size() != 0) && r[k];
    if (v) begin
      if (!m_locked) begin
        if (s) begin tgt = 0; m_slot = 1; m_locked = 1; end
      end else if (RESYNC && s && m_slot != 0) begin
        tgt = 0; m_slot = 1; m_serr = 1;
      end else begin
        tgt = m_slot; m_slot = (m_slot + 1) % NL;
      end
    end
    for (int k = 0; k < NL; k++) if (pops[k]) void'(q[k].pop_front());
    if (tgt >= 0) begin
      if (q[tgt].size() < D) q[tgt].push_back(d);
      else m_ovf[tgt] = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; din_valid = 1'b0; din_sof = 1'b0; lane_ready = '0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (lane_valid !== '0 || lane_dout !== '0 || aligned !== 1'b0 || overflow !== '0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b dout=%h aligned=%b ovf=%b serr=%b, want all zero",
               lane_valid, lane_dout, aligned, overflow, sync_err);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] dv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic         sv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(dv[i], 1'b1, sv[i], '1);
      else       step('0, 1'b0, 1'b0, '1);
      for (int k = 0; k < NL; k++) begin
        checks++;
        if (lane_valid[k] !== exp_valid(k) || lane_dout[k*W +: W] !== exp_word(k)) begin
          errors++;
          $display("FAIL basic c%0d lane%0d: got v=%b d=%h, want v=%b d=%h",
                   i, k, lane_valid[k], lane_dout[k*W +: W], exp_valid(k), exp_word(k));
        end
      end
      checks++;
      if (aligned !== 1'b1 || overflow !== '0) begin
        errors++;
        $display("FAIL basic c%0d flags: aligned=%b ovf=%b, want 1 00", i, aligned, overflow);
      end
    end
  endtask

  task automatic test_prelock();
    logic [W-1:0] dv [4] = '{8'hAA, 8'hBB, 8'h01, 8'h02};
    logic         sv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(dv[i], 1'b1, sv[i], '0);
      checks++;
      if (lane_valid !== {exp_valid(1), exp_valid(0)} || aligned !== m_locked) begin
        errors++;
        $display("FAIL prelock c%0d: valid=%b aligned=%b, want %b %b",
                 i, lane_valid, aligned, {exp_valid(1), exp_valid(0)}, m_locked);
      end
    end
    checks++;
    if (lane_dout !== {8'h02, 8'h01}) begin
      errors++;
      $display("FAIL prelock heads: got %h, want 0201", lane_dout);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 2*6; i++) step(8'h30 + 8'(i), 1'b1, (i == 0), 2'b01);
    checks++;
    if (overflow !== 2'b10) begin
      errors++;
      $display("FAIL overflow flags: got %b, want 10", overflow);
    end
    for (int i = 0; i < 6; i++) begin
      step('0, 1'b0, 1'b0, 2'b11);
      checks++;
      if (lane_valid[1] !== exp_valid(1) || lane_dout[W +: W] !== exp_word(1) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL overflow drain c%0d: got v=%b d=%h ovf=%b, want v=%b d=%h ovf=%b",
                 i, lane_valid[1], lane_dout[W +: W], overflow, exp_valid(1), exp_word(1), m_ovf);
      end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 2*D; i++) step(8'h50 + 8'(i), 1'b1, (i == 0), 2'b01);
    step(8'h70, 1'b1, 1'b0, 2'b01);
    step(8'h71, 1'b1, 1'b0, 2'b11);
    checks++;
    if (overflow !== 2'b00 || q[1].size() != D) begin
      errors++;
      $display("FAIL full_pop flags: ovf=%b, want 00 (model depth %0d)", overflow, q[1].size());
    end
    for (int i = 0; i < D + 1; i++) begin
      checks++;
      if (lane_valid[1] !== exp_valid(1) || lane_dout[W +: W] !== exp_word(1)) begin
        errors++;
        $display("FAIL full_pop order c%0d: got v=%b d=%h, want v=%b d=%h",
                 i, lane_valid[1], lane_dout[W +: W], exp_valid(1), exp_word(1));
      end
      step('0, 1'b0, 1'b0, 2'b11);
    end
  endtask

  task automatic test_sof_resync();
    logic [W-1:0] dv [4] = '{8'h11, 8'h22, 8'h33, 8'h5A};
    logic         sv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) step(dv[i], 1'b1, sv[i], '0);
    checks++;
    if (sync_err !== RESYNC || q[0].size() != (RESYNC ? 3 : 2)) begin
      errors++;
      $display("FAIL sof_resync flag: sync_err=%b, want %b", sync_err, RESYNC);
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NL; k++) begin
        checks++;
        if (lane_valid[k] !== exp_valid(k) || lane_dout[k*W +: W] !== exp_word(k)) begin
          errors++;
          $display("FAIL sof_resync c%0d lane%0d: got v=%b d=%h, want v=%b d=%h",
                   i, k, lane_valid[k], lane_dout[k*W +: W], exp_valid(k), exp_word(k));
        end
      end
      step('0, 1'b0, 1'b0, '1);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(8'h11, 1'b1, 1'b1, '0);
    step(8'h22, 1'b1, 1'b0, '0);
    step(8'h33, 1'b1, 1'b0, '0);
    rst = 1'b0;
    #1;
    checks++;
    if (lane_valid !== '0 || lane_dout !== '0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset async: valid=%b dout=%h aligned=%b, want 0 0 0", lane_valid, lane_dout, aligned);
    end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b1;
    step(8'h44, 1'b1, 1'b0, '0);
    checks++;
    if (lane_valid !== '0 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset relock-early: valid=%b aligned=%b, want 00 0", lane_valid, aligned);
    end
    step(8'h55, 1'b1, 1'b1, '0);
    checks++;
    if (lane_valid !== 2'b01 || lane_dout[W-1:0] !== 8'h55 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset relock: valid=%b d0=%h aligned=%b, want 01 55 1",
               lane_valid, lane_dout[W-1:0], aligned);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(W'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0), NL'($urandom));
      for (int k = 0; k < NL; k++) begin
        checks++;
        if (lane_valid[k] !== exp_valid(k) || lane_dout[k*W +: W] !== exp_word(k)) begin
          errors++;
          $display("FAIL random c%0d lane%0d: got v=%b d=%h, want v=%b d=%h",
                   i, k, lane_valid[k], lane_dout[k*W +: W], exp_valid(k), exp_word(k));
        end
      end
      checks++;
      if ({aligned, overflow, sync_err} !== {m_locked, m_ovf, m_serr}) begin
        errors++;
        $display("FAIL random c%0d flags: got aligned=%b ovf=%b serr=%b, want %b %b %b",
                 i, aligned, overflow, sync_err, m_locked, m_ovf, m_serr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prelock();
    test_overflow();
    test_full_pop();
    test_sof_resync();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
